mem_refill_arbiter: RTL and testbench
=====================================

Name: mem_refill_arbiter

Overview:
Sequences cache-line refills and write-backs between the instruction cache and the data cache over a single shared main-memory port.
Each cache raises a miss request and holds it until served. The arbiter grants one requester at a time, runs a WORDS-beat burst with a per-beat ack handshake, and pulses done on completion.
It sits below the cache tops; the caches keep their stall outputs asserted until done.

Parameters:
AW, 32, address width in bits
DW, 32, data word width in bits
WORDS, 4, words per cache line (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
i_req  in  1  icache line-fill request, held until i_done
i_addr  in  AW  icache miss address (any byte within the line)
i_rdata  out  DW  fill data to icache
i_rvalid  out  1  i_rdata valid this cycle
i_done  out  1  one-cycle pulse: icache burst complete
d_req  in  1  dcache request, held until d_done
d_we  in  1  1 = write-back line, 0 = line fill; sampled at grant
d_addr  in  AW  dcache line address
d_wdata  in  DW  current write-back word
d_wnext  out  1  write word consumed; dcache advances d_wdata next cycle
d_rdata  out  DW  fill data to dcache
d_rvalid  out  1  d_rdata valid this cycle
d_done  out  1  one-cycle pulse: dcache burst complete
mem_req  out  1  memory beat request
mem_we  out  1  memory write enable
mem_addr  out  AW  memory word address
mem_wdata  out  DW  memory write data
mem_ack  in  1  memory beat accepted/read data valid
mem_rdata  in  DW  memory read data
busy  out  1  burst in progress

Behaviour:
- FSM states: IDLE, BURST, DONE. Registers: state, grant (I/D), we_q, base address, beat counter (log2 WORDS bits), last_grant.
- Reset (asynchronous, immediate): state=IDLE, beat=0, last_grant=I. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, busy, *_rvalid, *_done, d_wnext, *_rdata.
- IDLE: request sampled at clock edge.
  - Only one req high: grant it.
  - Both high: grant the one opposite last_grant, so the first tie after reset goes to D.
  - On grant: capture base = addr with the low log2(WORDS*DW/8) bits cleared. Capture we_q = d_we for D, 0 for I. Set last_grant, go to BURST.
  - mem_req rises one cycle after req.
- BURST:
  - mem_req=1, mem_addr = base + beat*(DW/8), mem_we=we_q.
  - mem_wdata = d_wdata (combinational) when we_q, else 0.
  - Beat completes on any cycle with mem_ack=1:
    - Read: granted *_rvalid=1 and *_rdata=mem_rdata in that same cycle.
    - Write: d_wnext=1 in that same cycle.
    - beat increments.
  - mem_ack=0: outputs hold stable, no rvalid/wnext.
  - Ack on beat WORDS-1: beat wraps to 0, go to DONE.
- DONE: granted *_done=1 for exactly one cycle, mem_req=0, requests ignored, next state IDLE. Minimum burst-to-burst gap is 2 cycles (DONE, IDLE).
- busy=1 in BURST and DONE.
- Non-granted requester: rvalid, done and wnext stay 0 throughout.
- mem_ack in IDLE or DONE: ignored.
- Requester dropping req mid-burst: burst still runs to completion and done is still pulsed.
- Requests are not queued; a waiting requester simply keeps req high.
- Reset mid-burst: burst abandoned with no done pulse. After reset release, a still-held request is re-granted from beat 0.

Optional Feature:
MEM_ARB_PERF_EN
- Defined: adds two outputs:
  - perf_conflict_cnt [31:0]: increments on each IDLE cycle with i_req and d_req both high.
  - perf_wait_cnt [31:0]: increments on each cycle where any req is high but that requester is not in BURST/DONE.
  - Both counters wrap at 2^32 and reset to 0.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Icache fill (defaults):
  - Stimulus: i_req=1, i_addr=0x0000_1234, mem_ack=1 every cycle, mem_rdata=0x11,0x22,0x33,0x44.
  - Required: mem_req rises next cycle; mem_addr 0x1230, 0x1234, 0x1238, 0x123C; mem_we=0; i_rvalid 4 cycles carrying 0x11..0x44; i_done one pulse the cycle after the last ack; d_* outputs 0.
- Dcache write-back with slow memory:
  - Stimulus: d_req=1, d_we=1, d_addr=0x2008; dcache supplies 0xA, 0xB, 0xC, 0xD advancing on d_wnext; mem_ack high every third cycle.
  - Required: mem_addr 0x2000..0x200C; mem_we=1; mem_wdata matches each acked beat; exactly 4 d_wnext pulses; one d_done; no rvalid.
- Tie-break:
  - Stimulus: i_req and d_req rise together right after reset, both held.
  - Required: D served first, then I. Repeat the tie: D first again (last_grant=I).
- Stall hold:
  - Stimulus: mem_ack=0 for 10 cycles in BURST at beat 1.
  - Required: mem_addr stable at base+4, busy=1, no rvalid, no done.
- Reset mid-burst:
  - Stimulus: assert reset between clock edges at beat 2.
  - Required: mem_req and busy drop immediately. After release with i_req still high: burst restarts at base+0 and completes with exactly one done.
- Stray ack:
  - Stimulus: mem_ack=1 while IDLE with no requests.
  - Required: all *_rvalid, *_done and d_wnext stay 0.

Source files
------------

// File: rtl/mem_refill_arbiter.sv
// Shares one main-memory port between icache fills and dcache fills/write-backs, one WORDS-beat burst at a time.
// Optional MEM_ARB_PERF_EN adds conflict and wait performance counters.
module mem_refill_arbiter #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int WORDS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_rvalid,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_wnext,
  output logic [DW-1:0] d_rdata,
  output logic          d_rvalid,
  output logic          d_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_conflict_cnt,
  output logic [31:0]   perf_wait_cnt
`endif
);

  localparam int BW         = $clog2(WORDS);
  localparam int WORD_SHIFT = $clog2(DW / 8);
  localparam int LINE_SHIFT = $clog2(WORDS * DW / 8);
  localparam logic [AW-1:0] LINE_MASK  = ~((AW'(1) << LINE_SHIFT) - AW'(1));
  localparam logic [BW-1:0] LAST_BEAT  = BW'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

  state_t        r_state, w_state_next;
  logic          r_grant_d, w_grant_d_next;
  logic          r_we, w_we_next;
  logic          r_last_d, w_last_d_next;
  logic [AW-1:0] r_base, w_base_next;
  logic [BW-1:0] r_beat, w_beat_next;
  logic          w_pick_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_grant_d <= 1'b0;
      r_we      <= 1'b0;
      r_last_d  <= 1'b0;
      r_base    <= '0;
      r_beat    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_grant_d <= w_grant_d_next;
      r_we      <= w_we_next;
      r_last_d  <= w_last_d_next;
      r_base    <= w_base_next;
      r_beat    <= w_beat_next;
    end
  end

  // On a tie, the requester that was not served last wins.
  assign w_pick_d = d_req && (!i_req || !r_last_d);

  always_comb begin
    w_state_next   = r_state;
    w_grant_d_next = r_grant_d;
    w_we_next      = r_we;
    w_last_d_next  = r_last_d;
    w_base_next    = r_base;
    w_beat_next    = r_beat;
    i_rdata        = '0;
    i_rvalid       = 1'b0;
    i_done         = 1'b0;
    d_wnext        = 1'b0;
    d_rdata        = '0;
    d_rvalid       = 1'b0;
    d_done         = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    busy           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req || d_req) begin
          w_grant_d_next = w_pick_d;
          w_last_d_next  = w_pick_d;
          w_we_next      = w_pick_d ? d_we : 1'b0;
          w_base_next    = (w_pick_d ? d_addr : i_addr) & LINE_MASK;
          w_beat_next    = '0;
          w_state_next   = S_BURST;
        end
      end
      S_BURST: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_base + (AW'(r_beat) << WORD_SHIFT);
        mem_wdata = r_we ? d_wdata : '0;
        if (mem_ack) begin
          if (r_we) begin
            d_wnext = 1'b1;
          end else if (r_grant_d) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end else begin
            i_rvalid = 1'b1;
            i_rdata  = mem_rdata;
          end
          w_beat_next = r_beat + 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        i_done       = !r_grant_d;
        d_done       = r_grant_d;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

`ifdef MEM_ARB_PERF_EN
  logic w_i_waiting, w_d_waiting;
  assign w_i_waiting = i_req && !(busy && !r_grant_d);
  assign w_d_waiting = d_req && !(busy && r_grant_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_conflict_cnt <= '0;
      perf_wait_cnt     <= '0;
    end else begin
      if (r_state == S_IDLE && i_req && d_req) begin
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      end
      if (w_i_waiting || w_d_waiting) begin
        perf_wait_cnt <= perf_wait_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter: fills, write-back, tie-break, stall, reset mid-burst, stray ack.
module tb_mem_refill_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_rvalid, i_done, d_wnext, d_rvalid, d_done;
  logic        mem_req, mem_we, busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_refill_arbiter #(.AW(32), .DW(32), .WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wnext(d_wnext),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic do_reset();
    reset = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Observes until a done pulse; reports first burst address and which side finished.
  task automatic wait_burst(output logic [31:0] fa, output logic gi, output logic gd, output logic ok);
    logic seen;
    seen = 0; fa = 0; gi = 0; gd = 0; ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk); #1;
      if (mem_req && !seen) begin seen = 1; fa = mem_addr; end
      if (i_done || d_done) begin gi = i_done; gd = d_done; ok = 1; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_req = 1; d_req = 1; d_we = 1; mem_ack = 1;
    i_addr = 32'h1234; d_addr = 32'h5678; d_wdata = 32'hFFFF; mem_rdata = 32'hABCD;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({mem_req, mem_we, busy, i_rvalid, i_done, d_rvalid, d_done, d_wnext} !== 8'h00 ||
          mem_addr !== 0 || mem_wdata !== 0 || i_rdata !== 0 || d_rdata !== 0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got ctl=%b addr=%h wdata=%h ird=%h drd=%h expected all zero", c,
                 {mem_req, mem_we, busy, i_rvalid, i_done, d_rvalid, d_done, d_wnext},
                 mem_addr, mem_wdata, i_rdata, d_rdata);
      end
      @(negedge clk); #1;
    end
    $display("test_reset done");
  endtask

  task automatic test_icache_fill();
    logic [31:0] exp_d;
    do_reset();
    i_req = 1; i_addr = 32'h0000_1234; mem_ack = 1; mem_rdata = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++; $display("FAIL icache_req_latency got mem_req=%b expected 0", mem_req);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_d = 32'h11 * (k + 1);
      mem_rdata = exp_d;
      #1;
      checks++;
      if (mem_req !== 1 || mem_addr !== 32'h1230 + 4 * k || mem_we !== 0 || i_rvalid !== 1 ||
          i_rdata !== exp_d || i_done !== 0 || busy !== 1) begin
        failures++;
        $display("FAIL icache_beat%0d got req=%b addr=%h we=%b rv=%b rd=%h done=%b expected req=1 addr=%h we=0 rv=1 rd=%h done=0",
                 k, mem_req, mem_addr, mem_we, i_rvalid, i_rdata, i_done, 32'h1230 + 4 * k, exp_d);
      end
      checks++;
      if ({d_rvalid, d_done, d_wnext} !== 3'b000 || d_rdata !== 0) begin
        failures++; $display("FAIL icache_dside%0d got rv=%b done=%b wnext=%b rd=%h expected zeros",
                             k, d_rvalid, d_done, d_wnext, d_rdata);
      end
      $display("icache beat %0d addr=%h data=%h", k, mem_addr, i_rdata);
    end
    @(negedge clk); #1;
    checks++;
    if (i_done !== 1 || mem_req !== 0 || busy !== 1 || i_rvalid !== 0 || d_done !== 0) begin
      failures++; $display("FAIL icache_done got done=%b req=%b busy=%b rv=%b d_done=%b expected 1 0 1 0 0",
                           i_done, mem_req, busy, i_rvalid, d_done);
    end
    i_req = 0; mem_ack = 0;
    @(negedge clk); #1;
    checks++;
    if (i_done !== 0 || busy !== 0 || mem_req !== 0) begin
      failures++; $display("FAIL icache_after_done got done=%b busy=%b req=%b expected 0 0 0", i_done, busy, mem_req);
    end
  endtask

  task automatic test_writeback_slow();
    int nb, nd, rv_bad;
    do_reset();
    d_req = 1; d_we = 1; d_addr = 32'h2008;
    nb = 0; nd = 0; rv_bad = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      mem_ack = (cyc % 3 == 2);
      d_wdata = (nb < 4) ? 32'hA + nb : 32'h0;
      #1;
      if (i_rvalid || d_rvalid) rv_bad++;
      if (mem_req) begin
        checks++;
        if (mem_we !== 1) begin
          failures++; $display("FAIL wb_we cycle=%0d got %b expected 1", cyc, mem_we);
        end
      end
      if (mem_req && mem_ack) begin
        checks++;
        if (mem_addr !== 32'h2000 + 4 * nb || mem_wdata !== 32'hA + nb || d_wnext !== 1) begin
          failures++;
          $display("FAIL wb_beat%0d got addr=%h wdata=%h wnext=%b expected addr=%h wdata=%h wnext=1",
                   nb, mem_addr, mem_wdata, d_wnext, 32'h2000 + 4 * nb, 32'hA + nb);
        end
        $display("writeback beat %0d addr=%h wdata=%h", nb, mem_addr, mem_wdata);
      end
      if (d_wnext) nb++;
      if (d_done) begin nd++; d_req = 0; end
      @(negedge clk);
    end
    mem_ack = 0; d_we = 0;
    checks++;
    if (nb !== 4 || nd !== 1 || rv_bad !== 0) begin
      failures++; $display("FAIL wb_counts got wnext=%0d done=%0d rvalid=%0d expected 4 1 0", nb, nd, rv_bad);
    end
  endtask

  task automatic test_tie_break();
    logic [31:0] fa;
    logic gi, gd, ok;
    logic [31:0] exp_fa [3];
    logic        exp_gd [3];
    exp_fa[0] = 32'h200; exp_gd[0] = 1;
    exp_fa[1] = 32'h100; exp_gd[1] = 0;
    exp_fa[2] = 32'h200; exp_gd[2] = 1;
    do_reset();
    i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h100; d_addr = 32'h204; mem_ack = 1; mem_rdata = 32'h5A;
    for (int b = 0; b < 3; b++) begin
      wait_burst(fa, gi, gd, ok);
      checks++;
      if (!ok || fa !== exp_fa[b] || gd !== exp_gd[b] || gi !== !exp_gd[b]) begin
        failures++; $display("FAIL tie_burst%0d got ok=%b addr=%h i_done=%b d_done=%b expected ok=1 addr=%h d_done=%b",
                             b, ok, fa, gi, gd, exp_fa[b], exp_gd[b]);
      end
      $display("tie burst %0d served %s at %h", b, gd ? "D" : "I", fa);
    end
    i_req = 0; d_req = 0; mem_ack = 0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (busy !== 0 || mem_req !== 0) begin
      failures++; $display("FAIL tie_idle got busy=%b req=%b expected 0 0", busy, mem_req);
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0] fa;
    logic gi, gd, ok;
    do_reset();
    i_req = 1; i_addr = 32'h3008; mem_ack = 0; mem_rdata = 32'h77;
    @(negedge clk);
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (mem_addr !== 32'h3004 || busy !== 1 || mem_req !== 1 || i_rvalid !== 0 || i_done !== 0) begin
        failures++; $display("FAIL stall_hold cycle=%0d got addr=%h busy=%b req=%b rv=%b done=%b expected 00003004 1 1 0 0",
                             c, mem_addr, busy, mem_req, i_rvalid, i_done);
      end
      @(negedge clk);
    end
    $display("stall held 10 cycles at %h", mem_addr);
    mem_ack = 1;
    wait_burst(fa, gi, gd, ok);
    i_req = 0; mem_ack = 0;
    checks++;
    if (!ok || gi !== 1 || gd !== 0) begin
      failures++; $display("FAIL stall_complete got ok=%b i_done=%b d_done=%b expected 1 1 0", ok, gi, gd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] fa;
    logic seen;
    int nd, nrv;
    do_reset();
    i_req = 1; i_addr = 32'h4014; mem_ack = 1; mem_rdata = 32'h99;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1;
    checks++;
    if (mem_addr !== 32'h4018 || mem_req !== 1) begin
      failures++; $display("FAIL rst_mid_beat2 got addr=%h req=%b expected 00004018 1", mem_addr, mem_req);
    end
    #2 reset = 1;
    #1;
    checks++;
    if (mem_req !== 0 || busy !== 0 || i_rvalid !== 0) begin
      failures++; $display("FAIL rst_mid_drop got req=%b busy=%b rv=%b expected 0 0 0", mem_req, busy, i_rvalid);
    end
    @(negedge clk);
    reset = 0;
    seen = 0; fa = 0; nd = 0; nrv = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (mem_req && !seen) begin seen = 1; fa = mem_addr; end
      if (i_rvalid) nrv++;
      if (i_done) begin nd++; i_req = 0; end
    end
    mem_ack = 0;
    checks++;
    if (fa !== 32'h4010 || nd !== 1 || nrv !== 4) begin
      failures++; $display("FAIL rst_mid_restart got first=%h done=%0d rvalid=%0d expected 00004010 1 4", fa, nd, nrv);
    end
    $display("restart after reset first=%h dones=%0d", fa, nd);
  endtask

  task automatic test_stray_ack();
    do_reset();
    mem_ack = 1; mem_rdata = 32'hDEAD;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({i_rvalid, i_done, d_rvalid, d_done, d_wnext, mem_req, busy} !== 7'b0) begin
        failures++; $display("FAIL stray_ack cycle=%0d got %b expected 0000000", c,
                             {i_rvalid, i_done, d_rvalid, d_done, d_wnext, mem_req, busy});
      end
    end
    mem_ack = 0;
    $display("stray ack ignored");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_icache_fill();
    test_writeback_slow();
    test_tie_break();
    test_stall_hold();
    test_reset_mid_burst();
    test_stray_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
